carry_chain_sub_serial: RTL and testbench

//   Multi-cycle, slice-serial subtractor: diff = a - b - bin over WIDTH bits, one SLICE-bit

---
 rtl/carry_chain_sub_serial.sv | 169 ++++++++++++++++
 tb/tb_carry_chain_sub_serial.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_sub_serial.sv
// ---------------------------------------------------------------------------
// carry_chain_sub_serial
//   Slice-serial subtractor: diff = a - b - bin over WIDTH bits. One SLICE-bit
//   borrow-chain slice is evaluated per clock, with the borrow registered
//   between slices, so a wide subtract fits one narrow chain per cycle.
//   An operation takes NSLICE = WIDTH/SLICE cycles from accept to result.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, bin valid
//   in_ready   out  1      operands accepted this cycle if in_valid (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff/bout/overflow valid (DONE only, registered)
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      final borrow: 1 iff a < b + bin (unsigned)
//   overflow   out  1      signed overflow of the two's-complement subtract
// ---------------------------------------------------------------------------
module carry_chain_sub_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if (SLICE < 1) begin : g_bad_slice
      $error("SLICE must be at least 1");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [IDXW-1:0]   idx_q,       idx_d;
  logic              brw_q,       brw_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;
  logic [WIDTH-1:0]  diff_q,      diff_d;
  logic              bout_q,      bout_d;
  logic              ovf_q,       ovf_d;
  logic              out_valid_q, out_valid_d;

  // Current slice operands and the one-slice borrow-chain result.
  logic [SLICE-1:0]  sa, sb;
  logic [SLICE:0]    sub_res;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    // Zero-extended subtract: the extra MSB is the slice's borrow-out.
    sub_res = {1'b0, sa} - {1'b0, sb} - {{SLICE{1'b0}}, brw_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          diff_d  = '0;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) begin
            diff_d[i*SLICE +: SLICE] = sub_res[SLICE-1:0];
          end
        end
        brw_d = sub_res[SLICE];
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
          bout_d  = sub_res[SLICE];
          // Uses the completed difference (including the top slice written now).
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_valid_d = (state_d == S_DONE);
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      brw_q       <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      brw_q       <= brw_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_carry_chain_sub_serial.sv
module tb_carry_chain_sub_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  carry_chain_sub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference subtract, independent of slicing.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    logic [W:0] r;
    r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  // One full transaction: accept, latency check, optional backpressure, result check, drain.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input exp_t e, input int hold);
    int   lat;
    exp_t cur;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va; b = ~vb; bin = ~vbin;   // junk after accept must be ignored
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
      errors++;
      return;
    end
    cur = sb[0];
    for (int h = 0; h < hold; h++) begin
      // Offer a new operation while busy; it must not be taken.
      in_valid = 1'b1; a = 16'h5555; b = 16'h1111; bin = 1'b0;
      chk({name, "_hold_diff"}, 32'(diff), 32'(cur.diff));
      chk({name, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    cur = sb.pop_front();
    chk({name, "_diff"}, 32'(diff), 32'(cur.diff));
    chk({name, "_bout"}, 32'(bout), 32'(cur.bout));
    chk({name, "_ovf"}, 32'(overflow), 32'(cur.ovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_idle"}, 32'(in_ready), 32'd1);
    chk({name, "_keep_diff"}, 32'(diff), 32'(cur.diff));
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rbin;

    //             a         b        bin diff      bout ovf hold
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    vecs[1] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0};
    vecs[4] = '{16'h0008, 16'h000A, 1'b0, 16'hFFFE, 1'b1, 1'b0, 5};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 2};
    vecs[7] = '{16'hA5C3, 16'h3C5A, 1'b1, 16'h6968, 1'b0, 1'b1, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      e.diff = vecs[i].diff; e.bout = vecs[i].bout; e.ovf = vecs[i].ovf;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, e, vecs[i].hold);
    end

    // Abort during RUN after two slices have been processed.
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e.diff = 16'h0FF0; e.bout = 1'b0; e.ovf = 1'b0;
    run_op("post_abort", 16'h1234, 16'h0244, 1'b0, e, 0);

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, model(ra, rb, rbin), i % 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
